sha_pad_scheduler: RTL and testbench

//  Job scheduler in front of the SHA-256 message padder. Queues message-length

---
 rtl/sha_pad_scheduler.sv | 150 +++++++++++++++
 tb/tb_sha_pad_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_pad_scheduler.sv
// Purpose : queues SHA-256 padder jobs, launches them one at a time and steers each into a free bank.
// Latency : request to go >= 2 cycles; finish to done 1 cycle; minimum 3 cycles between go pulses.
// Backpressure: req_ready drops while the queue is full; the queue stalls while the next bank is occupied.
//
// Ports:
//   clk, reset                      clock and asynchronous active-low reset
//   host__sch__req_*                length request (valid/ready), host__sch__release* bank free pulse
//   sch__pad__*, pad__sch__finish   padder launch (go, length, bank) and completion pulse
//   sch__host__*                    done/error pulses, busy flag and queue occupancy
module sha_pad_scheduler #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int QUEUE_DEPTH        = 4,
  parameter int NUM_BANKS          = 4,
  parameter int TIMEOUT_CYCLES     = 255,
  localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1,
  localparam int QW = $clog2(QUEUE_DEPTH),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host__sch__req_valid,
  input  logic [LW-1:0] host__sch__req_length,
  output logic          sch__host__req_ready,
  input  logic          host__sch__release,
  input  logic [BW-1:0] host__sch__release_bank,
  output logic          sch__pad__go,
  output logic [LW-1:0] sch__pad__msg_length,
  output logic [BW-1:0] sch__pad__bank,
  input  logic          pad__sch__finish,
  output logic          sch__host__done,
  output logic [BW-1:0] sch__host__done_bank,
  output logic          sch__host__error,
  output logic [1:0]    sch__host__err_code,
  output logic          sch__host__busy,
  output logic [QW:0]   sch__host__queue_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] MAX_LEN    = LW'(MAX_MESSAGE_LENGTH);
  localparam logic [QW:0]   Q_FULL     = (QW + 1)'(QUEUE_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t               state;
  logic [LW-1:0]        q_mem [QUEUE_DEPTH];
  logic [QW-1:0]        q_head;
  logic [QW-1:0]        q_tail;
  logic [QW:0]          q_cnt;
  logic [NUM_BANKS-1:0] bank_busy;
  logic [BW-1:0]        ptr;
  logic [TW-1:0]        timer;

  logic accept;
  logic len_ok;
  logic push;
  logic bad_len;
  logic pop;

  // Ready is forced low during reset so every output reads 0 while reset is held.
  assign sch__host__req_ready = reset && (q_cnt != Q_FULL);

  assign accept  = host__sch__req_valid && sch__host__req_ready;
  assign len_ok  = (host__sch__req_length != '0) && (host__sch__req_length <= MAX_LEN);
  assign push    = accept && len_ok;
  assign bad_len = accept && !len_ok;

  // Strict round-robin: the head job waits for bank[ptr] rather than skipping ahead.
  assign pop = (state == IDLE) && (q_cnt != '0) && !bank_busy[ptr];

  assign sch__host__busy        = (state != IDLE) || (q_cnt != '0);
  assign sch__host__queue_count = q_cnt;

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) q_mem[q_tail] <= host__sch__req_length;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_head <= '0;
      q_tail <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) q_tail <= q_tail + QW'(1);
      if (pop)  q_head <= q_head + QW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (QW + 1)'(1);
        2'b01:   q_cnt <= q_cnt - (QW + 1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      bank_busy            <= '0;
      ptr                  <= '0;
      timer                <= '0;
      sch__pad__go         <= 1'b0;
      sch__pad__msg_length <= '0;
      sch__pad__bank       <= '0;
      sch__host__done      <= 1'b0;
      sch__host__done_bank <= '0;
      sch__host__error     <= 1'b0;
      sch__host__err_code  <= 2'b00;
    end else begin
      sch__pad__go        <= 1'b0;
      sch__host__done     <= 1'b0;
      sch__host__error    <= bad_len;
      sch__host__err_code <= {1'b0, bad_len};

      // Release first so a done to the same bank in this cycle overrides it.
      if (host__sch__release) bank_busy[host__sch__release_bank] <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            sch__pad__msg_length <= q_mem[q_head];
            sch__pad__bank       <= ptr;
            sch__pad__go         <= 1'b1;
            state                <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (pad__sch__finish) begin
            sch__host__done           <= 1'b1;
            sch__host__done_bank      <= sch__pad__bank;
            bank_busy[sch__pad__bank] <= 1'b1;
            ptr                       <= ptr + BW'(1);
            state                     <= IDLE;
          end else if (timer == TIMER_LAST) begin
            // This is the TIMEOUT_CYCLES-th WAIT cycle; the bank was never written, keep ptr.
            sch__host__error       <= 1'b1;
            sch__host__err_code[1] <= 1'b1;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_pad_scheduler.sv
module tb_sha_pad_scheduler;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_length = '0;
  logic       req_ready;
  logic       rel = 1'b0;
  logic [1:0] rel_bank = '0;
  logic       go;
  logic [6:0] msg_length;
  logic [1:0] bank;
  logic       finish = 1'b0;
  logic       done;
  logic [1:0] done_bank;
  logic       error;
  logic [1:0] err_code;
  logic       busy;
  logic [2:0] queue_count;

  sha_pad_scheduler dut (
    .clk                     (clk),
    .reset                   (reset),
    .host__sch__req_valid    (req_valid),
    .host__sch__req_length   (req_length),
    .sch__host__req_ready    (req_ready),
    .host__sch__release      (rel),
    .host__sch__release_bank (rel_bank),
    .sch__pad__go            (go),
    .sch__pad__msg_length    (msg_length),
    .sch__pad__bank          (bank),
    .pad__sch__finish        (finish),
    .sch__host__done         (done),
    .sch__host__done_bank    (done_bank),
    .sch__host__error        (error),
    .sch__host__err_code     (err_code),
    .sch__host__busy         (busy),
    .sch__host__queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  wire [20:0] all_outs = {go, done, error, err_code, busy, queue_count, req_ready,
                          msg_length, bank, done_bank};

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state
  logic [6:0] exp_q[$];
  logic [1:0] rel_q[$];
  logic [1:0] exp_ptr = '0;
  int finish_delay = 5;
  int fin_cnt = 0;
  int cyc = 0;
  int go_cyc = 0;
  int job_delay = 0;
  logic [6:0] job_len = '0;
  int go_cnt = 0;
  int done_cnt = 0;
  int timeout_cnt = 0;
  int illegal_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none required", name);
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  // Padder model plus output monitor; runs every cycle #1 after the edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    finish = 1'b0;
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) finish = 1'b1;
    end
    if (go) begin
      go_cnt++;
      if (exp_q.size() == 0) fail("go_without_request");
      else begin
        job_len = exp_q.pop_front();
        chk("go_msg_length", 32'(msg_length), 32'(job_len));
      end
      chk("go_bank", 32'(bank), 32'(exp_ptr));
      go_cyc = cyc;
      job_delay = finish_delay;
      if (finish_delay > 0) fin_cnt = finish_delay;
    end
    if (done) begin
      chk("done_bank", 32'(done_bank), 32'(exp_ptr));
      chk("done_latency", cyc - go_cyc, job_delay + 1);
      chk("held_msg_length", 32'(msg_length), 32'(job_len));
      rel_q.push_back(exp_ptr);
      exp_ptr = exp_ptr + 2'd1;
      done_cnt++;
    end
    if (error && err_code[1]) begin
      chk("timeout_latency", cyc - go_cyc, TIMEOUT + 1);
      timeout_cnt++;
    end
    if (error && err_code[0]) illegal_cnt++;
  end

  task automatic push_req(input int len);
    int n = 0;
    while (!req_ready && n < 300) begin
      cyc1();
      n++;
    end
    chk("ready_before_push", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_length = len[6:0];
    if (len >= 1 && len <= 55) exp_q.push_back(len[6:0]);
    cyc1();
    req_valid = 1'b0;
  endtask

  // Waits for done_cnt to reach target, handing finished banks back to the scheduler.
  task automatic drain(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      if (rel_q.size() > 0) begin
        rel = 1'b1;
        rel_bank = rel_q.pop_front();
      end else rel = 1'b0;
      cyc1();
      n++;
    end
    while (rel_q.size() > 0) begin
      rel = 1'b1;
      rel_bank = rel_q.pop_front();
      cyc1();
    end
    rel = 1'b0;
    chk("jobs_done", done_cnt, target);
  endtask

  typedef struct {
    int len;
    int delay;
    bit legal;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int g, d, ic, t0, n;

    tbl[0] = '{len: 5,   delay: 40, legal: 1'b1};
    tbl[1] = '{len: 0,   delay: 5,  legal: 1'b0};
    tbl[2] = '{len: 56,  delay: 5,  legal: 1'b0};
    tbl[3] = '{len: 55,  delay: 1,  legal: 1'b1};
    tbl[4] = '{len: 127, delay: 5,  legal: 1'b0};
    tbl[5] = '{len: 1,   delay: 3,  legal: 1'b1};
    tbl[6] = '{len: 30,  delay: 10, legal: 1'b1};

    // Reset state
    repeat (3) cyc1();
    chk("reset_outputs", 32'(all_outs), 32'd0);
    reset = 1'b1;
    cyc1();
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_count", 32'(queue_count), 32'd0);

    // Table: legal jobs complete, illegal lengths report error 01 and are dropped
    foreach (tbl[i]) begin
      g = go_cnt;
      d = done_cnt;
      ic = illegal_cnt;
      finish_delay = tbl[i].delay;
      push_req(tbl[i].len);
      if (tbl[i].legal) begin
        drain(d + 1, 300);
        chk("tbl_go_count", go_cnt, g + 1);
        chk("tbl_no_illegal", illegal_cnt, ic);
      end else begin
        cyc1();
        cyc1();
        chk("tbl_illegal_err", illegal_cnt, ic + 1);
        chk("tbl_illegal_count", 32'(queue_count), 32'd0);
        chk("tbl_illegal_no_go", go_cnt, g);
      end
    end

    // Four jobs fill every bank; the fifth waits for bank 0 to be released
    d = done_cnt;
    finish_delay = 5;
    for (int k = 0; k < 4; k++) push_req(20 + k);
    n = 0;
    while (done_cnt < d + 4 && n < 400) begin
      cyc1();
      n++;
    end
    chk("four_banks_done", done_cnt, d + 4);
    g = go_cnt;
    push_req(24);
    repeat (30) cyc1();
    chk("stall_no_go", go_cnt, g);
    chk("stall_count", 32'(queue_count), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    drain(d + 5, 300);

    // Timeout: no finish, then the same bank is reused
    d = done_cnt;
    t0 = timeout_cnt;
    finish_delay = 0;
    push_req(7);
    n = 0;
    while (timeout_cnt == t0 && n < 400) begin
      cyc1();
      n++;
    end
    chk("timeout_seen", timeout_cnt, t0 + 1);
    chk("timeout_no_done", done_cnt, d);
    finish_delay = 5;
    push_req(8);
    drain(d + 1, 300);

    // Queue fill, simultaneous push and pop, FIFO order
    d = done_cnt;
    finish_delay = 60;
    push_req(41);
    push_req(42);
    chk("push_pop_count", 32'(queue_count), 32'd1);
    push_req(43);
    push_req(44);
    push_req(45);
    chk("full_count", 32'(queue_count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    finish_delay = 5;
    push_req(46);
    chk("refill_count", 32'(queue_count), 32'd4);
    drain(d + 6, 1000);

    // Reset in WAIT aborts silently; the late finish is ignored
    finish_delay = 20;
    g = go_cnt;
    push_req(9);
    push_req(11);
    n = 0;
    while (go_cnt == g && n < 20) begin
      cyc1();
      n++;
    end
    chk("reset_job_started", go_cnt, g + 1);
    repeat (5) cyc1();
    reset = 1'b0;
    #1;
    chk("midjob_reset_outputs", 32'(all_outs), 32'd0);
    exp_q.delete();
    rel_q.delete();
    exp_ptr = '0;
    d = done_cnt;
    g = go_cnt;
    repeat (3) cyc1();
    reset = 1'b1;
    repeat (30) cyc1();
    chk("after_reset_no_done", done_cnt, d);
    chk("after_reset_no_go", go_cnt, g);
    chk("after_reset_count", 32'(queue_count), 32'd0);
    chk("after_reset_busy", 32'(busy), 32'd0);
    finish_delay = 5;
    push_req(12);
    drain(d + 1, 300);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
